// File: rtl/ibex_rf_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package ibex_rf_arb_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Under RV32E only x0..x15 exist, so any address with bit 4 set is illegal.
  function automatic logic is_legal_waddr(input logic [RegAddrW-1:0] addr, input logic rv32e);
    return !(rv32e && addr[RegAddrW-1]);
  endfunction

endpackage

// File: rtl/ibex_rf_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, searching upward
// and wrapping. Produces a one-hot grant, its index and an any-grant flag.
module ibex_rf_rr_picker #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] w_cand;

  // Cyclic priority search starting at the pointer.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    w_cand = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!any_o && req_i[w_cand]) begin
        any_o         = 1'b1;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter: round-robin between writeback requesters, with a lock
// mode reserving the port for requester 0, a registered output stage and x0/RV32E filtering.
// Optional macro IBEX_RF_WPORT_FWD_EN adds a combinational bypass of the landing write.
module ibex_rf_wport_arbiter
  import ibex_rf_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  localparam int unsigned IdxW     = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [RegAddrW*NumReq-1:0]    req_addr_i,
  input  logic [DataWidth*NumReq-1:0]   req_data_i,
  input  logic                          lock_i,
  output logic                          rf_we_o,
  output logic [RegAddrW-1:0]           rf_waddr_o,
  output logic [DataWidth-1:0]          rf_wdata_o,
  output logic [IdxW-1:0]               grant_idx_o,
  output logic                          locked_o,
  output logic                          illegal_wr_o
`ifdef IBEX_RF_WPORT_FWD_EN
  ,
  input  logic [RegAddrW-1:0]           fwd_raddr_i,
  output logic                          fwd_hit_o,
  output logic [DataWidth-1:0]          fwd_data_o
`endif
);

  arb_state_e            r_state, w_state_next;
  logic [IdxW-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [IdxW-1:0]       r_grant_idx;
  logic                  r_we, r_illegal;
  logic [RegAddrW-1:0]   r_waddr;
  logic [DataWidth-1:0]  r_wdata;

  logic                  w_lock_gate;
  logic [NumReq-1:0]     w_req_elig, w_gnt;
  logic [IdxW-1:0]       w_gnt_idx;
  logic                  w_gnt_any;
  logic [RegAddrW-1:0]   w_sel_addr;
  logic [DataWidth-1:0]  w_sel_data;
  logic                  w_legal, w_do_write, w_do_illegal;

  // Lock FSM next state; gating also covers the cycle lock_i rises so requester 0 owns it.
  always_comb begin
    w_state_next = r_state;
    w_lock_gate  = 1'b0;
    unique case (r_state)
      ARB: begin
        if (lock_i) begin
          w_state_next = LOCKED;
          w_lock_gate  = 1'b1;
        end
      end
      LOCKED: begin
        w_lock_gate = 1'b1;
        if (!lock_i) w_state_next = ARB;
      end
      default: w_state_next = ARB;
    endcase
  end

  // While gated only requester 0 is eligible.
  always_comb begin
    w_req_elig = req_valid_i;
    if (w_lock_gate) w_req_elig = {{(NumReq-1){1'b0}}, req_valid_i[0]};
  end

  ibex_rf_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i (w_req_elig),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_gnt_idx),
    .any_o (w_gnt_any)
  );

  assign req_ready_o = w_gnt;

  // Select the granted request and classify it; pointer advances only outside lock.
  always_comb begin
    w_sel_addr    = req_addr_i[w_gnt_idx*RegAddrW +: RegAddrW];
    w_sel_data    = req_data_i[w_gnt_idx*DataWidth +: DataWidth];
    w_legal       = is_legal_waddr(w_sel_addr, RV32E);
    w_do_write    = w_gnt_any & w_legal & (w_sel_addr != '0);
    w_do_illegal  = w_gnt_any & ~w_legal;
    w_rr_ptr_next = r_rr_ptr;
    if (w_gnt_any && !w_lock_gate) begin
      w_rr_ptr_next = (w_gnt_idx == IdxW'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Arbitration state: FSM, round-robin pointer and last granted index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      if (w_gnt_any) r_grant_idx <= w_gnt_idx;
    end
  end

  // Output stage; address/data hold whenever no write is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_we      <= w_do_write;
      r_illegal <= w_do_illegal;
      if (w_do_write) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign rf_we_o      = r_we;
  assign rf_waddr_o   = r_waddr;
  assign rf_wdata_o   = r_wdata;
  assign grant_idx_o  = r_grant_idx;
  assign locked_o     = (r_state == LOCKED);
  assign illegal_wr_o = r_illegal;

`ifdef IBEX_RF_WPORT_FWD_EN
  assign fwd_hit_o  = r_we & (r_waddr == fwd_raddr_i) & (fwd_raddr_i != '0);
  assign fwd_data_o = r_wdata;
`endif

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Bench for ibex_rf_wport_arbiter: two instances (RV32I and RV32E) share the stimulus and are
// checked against a cycle-level behavioural model of the arbitration and filtering rules.
module tb_ibex_rf_wport_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_valid_i;
  logic [5*N-1:0]  req_addr_i;
  logic [DW*N-1:0] req_data_i;
  logic          lock_i;

  logic [N-1:0]  rdy_b, rdy_e;
  logic          we_b, we_e, lkd_b, lkd_e, ill_b, ill_e;
  logic [4:0]    wa_b, wa_e;
  logic [DW-1:0] wd_b, wd_e;
  logic [1:0]    gi_b, gi_e;
`ifdef IBEX_RF_WPORT_FWD_EN
  logic [4:0]    fwd_raddr;
  logic          fh_b, fh_e;
  logic [DW-1:0] fd_b, fd_e;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wport_arbiter #(.NumReq(N), .DataWidth(DW), .RV32E(1'b0)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(rdy_b),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .lock_i(lock_i), .rf_we_o(we_b),
    .rf_waddr_o(wa_b), .rf_wdata_o(wd_b), .grant_idx_o(gi_b), .locked_o(lkd_b),
    .illegal_wr_o(ill_b)
`ifdef IBEX_RF_WPORT_FWD_EN
    , .fwd_raddr_i(fwd_raddr), .fwd_hit_o(fh_b), .fwd_data_o(fd_b)
`endif
  );

  ibex_rf_wport_arbiter #(.NumReq(N), .DataWidth(DW), .RV32E(1'b1)) dut_e (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(rdy_e),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .lock_i(lock_i), .rf_we_o(we_e),
    .rf_waddr_o(wa_e), .rf_wdata_o(wd_e), .grant_idx_o(gi_e), .locked_o(lkd_e),
    .illegal_wr_o(ill_e)
`ifdef IBEX_RF_WPORT_FWD_EN
    , .fwd_raddr_i(fwd_raddr), .fwd_hit_o(fh_e), .fwd_data_o(fd_e)
`endif
  );

  // Stimulus state: per-requester pending write, and the lock request.
  bit          v[N];
  logic [4:0]  a[N];
  logic [31:0] d[N];
  bit          lk;

  // Reference model state; index 0 = RV32I instance, 1 = RV32E instance.
  int          m_ptr;
  bit          m_locked;
  int          m_gidx;
  bit          m_we[2];
  bit          m_ill[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_gidx = 0;
    for (int j = 0; j < 2; j++) begin
      m_we[j] = 0; m_ill[j] = 0; m_addr[j] = '0; m_data[j] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]        = v[i];
      req_addr_i[5*i +: 5]  = a[i];
      req_data_i[32*i +: 32] = d[i];
    end
    lock_i = lk;
  endtask

  // Winner under the current rules, or -1 when nobody may be accepted.
  function automatic int model_pick();
    bit gate = lk || m_locked;
    for (int j = 0; j < N; j++) begin
      int c = (m_ptr + j) % N;
      if (v[c] && (!gate || c == 0)) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("we_b", 64'(we_b), 64'(m_we[0]));      chk("we_e", 64'(we_e), 64'(m_we[1]));
    chk("waddr_b", 64'(wa_b), 64'(m_addr[0])); chk("waddr_e", 64'(wa_e), 64'(m_addr[1]));
    chk("wdata_b", 64'(wd_b), 64'(m_data[0])); chk("wdata_e", 64'(wd_e), 64'(m_data[1]));
    chk("illegal_b", 64'(ill_b), 64'(m_ill[0])); chk("illegal_e", 64'(ill_e), 64'(m_ill[1]));
    chk("gidx_b", 64'(gi_b), 64'(m_gidx));     chk("gidx_e", 64'(gi_e), 64'(m_gidx));
    chk("locked_b", 64'(lkd_b), 64'(m_locked)); chk("locked_e", 64'(lkd_e), 64'(m_locked));
  endtask

  // One clock cycle: called at posedge+1, drives, checks ready, then registered outputs.
  task automatic step();
    int k;
    bit gate;
    logic [N-1:0] er;
    drive();
    #1;
    k = model_pick();
    gate = lk || m_locked;
    er = '0;
    if (k >= 0) er[k] = 1'b1;
    chk("ready_b", 64'(rdy_b), 64'(er));
    chk("ready_e", 64'(rdy_e), 64'(er));
    @(posedge clk_i);
    #1;
    if (k >= 0) begin
      m_gidx = k;
      if (!gate) m_ptr = (k + 1) % N;
      for (int j = 0; j < 2; j++) begin
        bit legal = !(j == 1 && a[k] >= 5'd16);
        m_we[j]  = legal && (a[k] != 5'd0);
        m_ill[j] = !legal;
        if (m_we[j]) begin
          m_addr[j] = a[k];
          m_data[j] = d[k];
        end
      end
      v[k] = 0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        m_we[j] = 0; m_ill[j] = 0;
      end
    end
    m_locked = lk;
    check_outputs();
  endtask

  // Let every pending write be accepted (bounded) so stimulus never withdraws a valid.
  task automatic drain();
    lk = 0;
    for (int n = 0; n < 2 * N + 2; n++) begin
      if (v[0] || v[1] || v[2]) step();
    end
    chk("drained", 64'(req_valid_i & ~rdy_b), 64'(0));
  endtask

  // Requester obligation: a valid that was not accepted stays with the same addr/data.
  logic [N-1:0]    p_pend;
  logic [5*N-1:0]  p_addr;
  logic [DW*N-1:0] p_data;
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int i = 0; i < N; i++) begin
        if (p_pend[i]) begin
          total++;
          assert (req_valid_i[i] && req_addr_i[5*i +: 5] == p_addr[5*i +: 5] &&
                  req_data_i[32*i +: 32] == p_data[32*i +: 32]) else begin
            bad++;
            $error("FAIL hold_req%0d observed=%0b expected=1", i, req_valid_i[i]);
          end
        end
      end
      p_pend = req_valid_i & ~rdy_b;
    end else begin
      p_pend = '0;
    end
    p_addr = req_addr_i;
    p_data = req_data_i;
  end

  initial begin
    int exp_g[4] = '{0, 1, 2, 0};
    for (int i = 0; i < N; i++) begin
      v[i] = 0; a[i] = '0; d[i] = '0;
    end
    lk = 0;
`ifdef IBEX_RF_WPORT_FWD_EN
    fwd_raddr = '0;
`endif
    model_reset();
    drive();
    #12;
    check_outputs();
    chk("reset_ready", 64'(rdy_b), 64'(0));
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // All three requesting, held: round-robin 0,1,2,0.
    for (int s = 0; s < 4; s++) begin
      v[0] = 1; v[1] = 1; v[2] = 1;
      a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      d[0] = 32'hAAAA_0001; d[1] = 32'hBBBB_0002; d[2] = 32'hCCCC_0003;
      step();
      chk("rr_gidx", 64'(gi_b), 64'(exp_g[s]));
      chk("rr_waddr", 64'(wa_b), 64'(exp_g[s] + 1));
    end
    drain();

    // Single requester 2.
    v[2] = 1; a[2] = 5'd5; d[2] = 32'hDEADBEEF;
    step();
    chk("single_we", 64'(we_b), 64'(1));
    chk("single_data", 64'(wd_b), 64'(32'hDEADBEEF));
    step();
    chk("single_we_off", 64'(we_b), 64'(0));

    // x0 write, then addr 17 (illegal only under RV32E).
    v[1] = 1; a[1] = 5'd0; d[1] = 32'h1111_2222;
    step();
    chk("x0_ill", 64'(ill_e), 64'(0));
    v[1] = 1; a[1] = 5'd17; d[1] = 32'h3333_4444;
    step();
    chk("rv32e_ill", 64'(ill_e), 64'(1));
    chk("rv32e_we", 64'(we_e), 64'(0));
    step();
    chk("rv32e_ill_pulse", 64'(ill_e), 64'(0));

    // Lock with requesters 1,2 pending, then requester 0, then release.
    lk = 1;
    v[1] = 1; a[1] = 5'd8; d[1] = 32'h0808_0808;
    v[2] = 1; a[2] = 5'd9; d[2] = 32'h0909_0909;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("lock_locked", 64'(lkd_b), 64'(1));
    end
    v[0] = 1; a[0] = 5'd4; d[0] = 32'h0404_0404;
    step();
    chk("lock_gnt0", 64'(gi_b), 64'(0));
    lk = 0;
    for (int s = 0; s < 4; s++) step();

    // Reset while a write is on the port.
    v[0] = 1; v[1] = 1; v[2] = 1;
    a[0] = 5'd10; a[1] = 5'd11; a[2] = 5'd12;
    step();
    chk("pre_reset_we", 64'(we_b), 64'(1));
    rst_ni = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) v[i] = 0;
    chk("async_reset_we_b", 64'(we_b), 64'(0));
    chk("async_reset_we_e", 64'(we_e), 64'(0));
    drive();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    check_outputs();
    v[0] = 1; v[1] = 1; v[2] = 1;
    step();
    chk("post_reset_gnt0", 64'(gi_b), 64'(0));
    drain();

`ifdef IBEX_RF_WPORT_FWD_EN
    v[0] = 1; a[0] = 5'd7; d[0] = 32'h0000_1234;
    step();
    fwd_raddr = 5'd7;
    #1;
    chk("fwd_hit", 64'(fh_b), 64'(1));
    chk("fwd_data", 64'(fd_b), 64'(32'h1234));
    fwd_raddr = 5'd0;
    #1;
    chk("fwd_x0", 64'(fh_b), 64'(0));
    @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
`endif

    // Randomized traffic with occasional lock toggling.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(1, 0) == 1)) begin
          v[i] = 1;
          a[i] = 5'($urandom);
          d[i] = $urandom;
        end
      end
      if ($urandom_range(7, 0) == 0) lk = !lk;
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
